// File: rtl/jtcps1_watch_cnt.sv
// jtcps1_watch_cnt: debug-watch block for the CPS1 video/bus path.
// Each channel is sampled on pxl_cen. Rising edges are stretched and
// OR-reduced into watch, and they set a per-channel sticky flag.
// Build option JTCPS1_WATCH_CNT_EN adds per-frame saturating edge
// counters, read back through cnt_sel. Without that macro, cnt_sel is
// tied to 0 and VB/sel are ignored.
module jtcps1_watch_cnt #(
  parameter int W    = 16,
  parameter int STRW = 4,
  parameter int CNTW = 12,
  parameter int SELW = 4
) (
  input  logic            rst,
  input  logic            clk,
  input  logic            pxl_cen,
  input  logic            VB,
  input  logic [W-1:0]    sig_in,
  input  logic [W-1:0]    mask,
  input  logic [STRW-1:0] stretch,
  input  logic [SELW-1:0] sel,
  input  logic            clr,
  output logic            watch,
  output logic [W-1:0]    sticky,
  output logic [CNTW-1:0] cnt_sel
);

  // arm[i] is set by the first low sample after reset. A channel that was
  // already high when reset was released therefore gives no edge and no
  // watch until it has been seen low.
  logic [W-1:0]    s_d;
  logic [W-1:0]    arm;
  logic [W-1:0]    edge_det;
  logic [W-1:0]    str;
  logic [STRW-1:0] scnt [W];

  // Edge detect (cen-qualified) and stretched level per channel
  always_comb begin
    edge_det = pxl_cen ? (sig_in & ~s_d & arm) : '0;
    for (int i = 0; i < W; i++) begin
      str[i] = (s_d[i] & arm[i]) | (scnt[i] != '0);
    end
  end

  // Input sampling and arming on the pixel timebase
  always_ff @(posedge clk) begin
    if (rst) begin
      s_d <= '0;
      arm <= '0;
    end else if (pxl_cen) begin
      s_d <= sig_in;
      arm <= arm | ~sig_in;
    end
  end

  // Stretch counters: load on edge, hold while the sample is still high,
  // count down once it is low. An L-cycle pulse then lasts L+stretch cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < W; i++) scnt[i] <= '0;
    end else if (pxl_cen) begin
      for (int i = 0; i < W; i++) begin
        if (edge_det[i])
          scnt[i] <= stretch;
        else if (!s_d[i] && scnt[i] != '0)
          scnt[i] <= scnt[i] - STRW'(1);
      end
    end
  end

  // Masked OR of stretched channels, registered every clk
  always_ff @(posedge clk) begin
    if (rst) watch <= 1'b0;
    else     watch <= |(str & mask);
  end

  // Sticky flags, cleared by clr, which wins over a same-cycle edge
  always_ff @(posedge clk) begin
    if (rst || clr) sticky <= '0;
    else            sticky <= sticky | edge_det;
  end

`ifdef JTCPS1_WATCH_CNT_EN
  localparam logic [CNTW-1:0] CNT_MAX = '1;

  logic            vb_d;
  logic            vb_rise;
  logic [CNTW-1:0] lc [W];
  logic [CNTW-1:0] fc [W];
  logic [CNTW-1:0] fc_mux;

  assign vb_rise = pxl_cen & VB & ~vb_d;

  // VB delay register, sampled on the pixel timebase
  always_ff @(posedge clk) begin
    if (rst)          vb_d <= 1'b0;
    else if (pxl_cen) vb_d <= VB;
  end

  // Live and frame counters. An edge in the frame-closing cycle counts
  // toward the new frame.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < W; i++) begin
        lc[i] <= '0;
        fc[i] <= '0;
      end
    end else if (vb_rise) begin
      for (int i = 0; i < W; i++) begin
        fc[i] <= lc[i];
        lc[i] <= edge_det[i] ? CNTW'(1) : '0;
      end
    end else begin
      for (int i = 0; i < W; i++) begin
        if (edge_det[i] && lc[i] != CNT_MAX) lc[i] <= lc[i] + CNTW'(1);
      end
    end
  end

  // Select mux. Any sel with no matching channel reads 0.
  always_comb begin
    fc_mux = '0;
    for (int i = 0; i < W; i++) begin
      if (sel == SELW'(i)) fc_mux = fc[i];
    end
  end

  // Registered read-back of the selected previous-frame count
  always_ff @(posedge clk) begin
    if (rst || clr) cnt_sel <= '0;
    else            cnt_sel <= fc_mux;
  end
`else
  logic unused_cnt;

  assign cnt_sel    = '0;
  assign unused_cnt = ^{VB, sel};
`endif

endmodule

// File: doc/jtcps1_watch_cnt.md
# jtcps1_watch_cnt

Parametrised debug-watch block for the CPS1 video/bus path. Each of W input channels is sampled on the pixel clock enable, rising edges are detected, pulses are stretched by a run-time programmable number of pixel cycles, masked and OR-reduced into a single `watch` output. It also keeps per-channel sticky flags and per-frame saturating edge counters, one of which is read back through a select port. It sits beside the video/PPU logic and drives a debug LED or OSD pin.

## Interface
- `W`, 16, number of watched channels (1..32)
- `STRW`, 4, width of the stretch-length field
- `CNTW`, 12, width of each per-channel edge counter
- `SELW`, 4, width of channel select; must satisfy 2**SELW >= W

- `rst`  in  1  synchronous reset, active-high
- `clk`  in  1  system clock; all logic on posedge
- `pxl_cen`  in  1  pixel clock enable; sampling/stretch timebase
- `VB`  in  1  vertical blank; rising edge closes a frame
- `sig_in`  in  W  raw debug signals
- `mask`  in  W  per-channel enable for `watch`; 1 = included
- `stretch`  in  STRW  extra pixel cycles added after each pulse
- `sel`  in  SELW  channel whose frame count appears on `cnt_sel`
- `clr`  in  1  single-clk pulse; clears sticky flags and all counters
- `watch`  out  1  OR of masked, stretched channels
- `sticky`  out  W  bit set on first rising edge of channel, held until `clr`
- `cnt_sel`  out  CNTW  previous-frame edge count of channel `sel`

## Operation
- Sampling: on `pxl_cen`, `s_d[i] <= sig_in[i]`; `edge[i] = sig_in[i] & ~s_d[i]` evaluated only when `pxl_cen`.
- Stretch counter per channel (STRW bits), on `pxl_cen`: if `edge[i]`, load `stretch`; else if nonzero, decrement. Retriggering mid-stretch reloads.
- `str[i] = s_d[i] | (scnt[i] != 0)`: high input of L cen cycles yields L + `stretch` cen cycles of `str`. `stretch`=0 gives plain level follow.
- `watch <= |(str & mask)` every clk (not gated by cen).
- Sticky: `sticky[i] <= 1` on `edge[i]`; independent of `mask`.
- Frame counters: live counter `lc[i]` increments on `edge[i]`, saturating at 2**CNTW-1 (no wrap). On VB rising edge (sampled at `pxl_cen` with its own delay register): `fc[i] <= lc[i]` for all i, `lc[i] <= edge[i] ? 1 : 0` (edge in the closing cycle counts in the new frame).
- `cnt_sel <= fc[sel]`, registered; `sel` >= W returns 0.
- `clr`: clears `sticky`, `lc`, `fc`, `cnt_sel` in that clk; takes priority over edge and frame events in the same cycle. Stretch counters and `s_d` unaffected.
- Reset: `s_d`, stretch counters, `sticky`, `lc`, `fc`, VB delay register, `watch`, `cnt_sel` all 0. Channel already high at reset release produces edge only after a low sample.

## Timing
- `sig_in` high at cen edge k: `s_d` high after edge k, `watch` high after next clk edge (2-clk latency); `sticky` high after edge k.
- `watch` falls 1 clk after `str` falls; `mask` change reflected after 1 clk.
- `lc` updates the same clk as edge detection; `fc` updates on the VB-edge cen cycle; `cnt_sel` valid 1 clk after `fc` or `sel` changes.
- `stretch` is sampled only at load time; changing it does not affect running counts.

## Configuration
- `JTCPS1_WATCH_CNT_EN` defined: live/frame counters and `cnt_sel` mux are built.
- Not defined: no counter registers; `cnt_sel` tied to 0; `VB` and `sel` ignored; `watch` and `sticky` behave identically.

## Test plan
- W=16, stretch=3, mask=all 1: 1-cen pulse on ch 5 -> `watch` high exactly 4 cen periods, `sticky`=0x0020.
- mask=0xFFDF, same pulse on ch 5 -> `watch` stays 0, `sticky[5]`=1.
- 7 pulses on ch 2 between VB edges, sel=2 (counters enabled) -> after VB rise `cnt_sel`=7; next frame with 0 pulses -> `cnt_sel`=0.
- CNTW=4, 20 pulses on ch 0 in one frame -> `cnt_sel`=15 (saturated).
- Edge on ch 1 coincident with VB rise -> old frame excludes it, next frame reports it; `clr` in same cycle -> all counts and `sticky` 0.
- Assert `rst` mid-stretch with ch 3 held high -> `watch`=0 after reset, no edge until ch 3 goes low then high.
